pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush and a stall counter. It is the next-generation replacement for the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage carries a control bundle, which is zeroed on bubbles and flushes, and a data bundle. The skid buffer lets back-pressure from a downstream stall stop the stage without a combinational ready path and without losing a transfer.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_entry.sv | 52 +++++
 rtl/pipe_stage_skid.sv | 191 +++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the skid-buffered pipeline stage:
//   - pipe_state_e : occupancy of the stage (EMPTY / ONE / TWO entries held)
//   - *_DEF        : default widths of the data bundle, control bundle and
//                    stall counter
//   - SLOT_MAIN / SLOT_SKID : indices of the two storage slots
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int DATA_W_DEF = 96;
    localparam int CTRL_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    // Slot indices. The main slot drives the stage outputs. The skid slot
    // catches the one transfer that arrives after downstream stalls.
    localparam int SLOT_MAIN = 0;
    localparam int SLOT_SKID = 1;
    localparam int NUM_SLOTS = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
// One storage slot of the pipeline stage: a control bundle plus a data bundle.
//
// Ports:
//   clk          in   clock, rising edge
//   srst         in   synchronous active-high reset; zeroes ctrl and data
//   load_i       in   capture ctrl_i/data_i at the next edge
//   clear_ctrl_i in   zero the control bundle and keep the data. Wins over
//                     load_i, so a cleared slot never carries live control.
//   ctrl_i       in   control bundle to load
//   data_i       in   data bundle to load
//   ctrl_o       out  registered control bundle
//   data_o       out  registered data bundle
// ---------------------------------------------------------------------------
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load_i,
    input  logic              clear_ctrl_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else if (clear_ctrl_i) begin
            // Data is kept on purpose. Consumers ignore it while the
            // control bundle is zero.
            ctrl_q <= '0;
        end else if (load_i) begin
            ctrl_q <= ctrl_i;
            data_q <= data_i;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Pipeline stage register with a valid/ready handshake, a one-entry skid
// buffer, a synchronous flush and a saturating stall counter.
//
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   synchronous active-high reset; takes priority over Flush
//   Flush      in   synchronous flush; empties the stage and keeps the data
//   InValid    in   upstream presents an entry
//   InReady    out  stage can accept. It depends only on state, Flush and
//                   Reset.
//   InCtrl     in   upstream control bundle
//   InData     in   upstream data bundle
//   OutValid   out  stage presents an entry (registered)
//   OutReady   in   downstream accepts
//   OutCtrl    out  registered control bundle; zero whenever OutValid=0
//   OutData    out  registered data bundle; holds its value when OutValid=0
//   StallCount out  saturating count of cycles with OutValid && !OutReady
// ---------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [CTRL_W-1:0] InCtrl,
    input  logic [DATA_W-1:0] InData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [DATA_W-1:0] OutData,
    output logic [CNT_W-1:0]  StallCount
);

    // -----------------------------------------------------------------------
    // State and handshake
    // -----------------------------------------------------------------------
    pipe_state_e state_q, state_d;

    // OutValid has its own register so that the output comes straight from a
    // flop and not from a decode of the state.
    logic out_valid_q, out_valid_d;

    logic in_ready;
    logic in_xfer;
    logic out_xfer;

    // Ready does not look at OutReady. The skid slot absorbs the one
    // transfer that can arrive in the cycle after downstream stalls.
    assign in_ready = (state_q != TWO) && !Flush && !Reset;
    assign in_xfer  = InValid && in_ready;
    assign out_xfer = out_valid_q && OutReady;

    // -----------------------------------------------------------------------
    // Slot control
    // -----------------------------------------------------------------------
    logic [NUM_SLOTS-1:0] slot_load;
    logic [NUM_SLOTS-1:0] slot_clr;
    logic                 main_from_skid;

    logic [CTRL_W-1:0] slot_ctrl_in  [NUM_SLOTS];
    logic [DATA_W-1:0] slot_data_in  [NUM_SLOTS];
    logic [CTRL_W-1:0] slot_ctrl_out [NUM_SLOTS];
    logic [DATA_W-1:0] slot_data_out [NUM_SLOTS];

    always_comb begin
        state_d        = state_q;
        slot_load      = '0;
        slot_clr       = '0;
        main_from_skid = 1'b0;

        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    slot_load[SLOT_MAIN] = 1'b1;
                    state_d              = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    // Streaming: replace the departing entry in place.
                    slot_load[SLOT_MAIN] = 1'b1;
                end else if (in_xfer) begin
                    slot_load[SLOT_SKID] = 1'b1;
                    state_d              = TWO;
                end else if (out_xfer) begin
                    slot_clr[SLOT_MAIN]  = 1'b1;
                    state_d              = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low in TWO, so only the drain case exists.
                if (out_xfer) begin
                    slot_load[SLOT_MAIN] = 1'b1;
                    main_from_skid       = 1'b1;
                    slot_clr[SLOT_SKID]  = 1'b1;
                    state_d              = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush overrides every transition. Both slots lose their control
        // bundle and keep their data. A downstream transfer in the same cycle
        // has already seen the unchanged outputs and still completes.
        if (Flush) begin
            state_d   = EMPTY;
            slot_load = '0;
            slot_clr  = '1;
        end

        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage slots. The main slot loads from the skid slot while draining
    // and from the upstream port otherwise. The skid slot only ever loads
    // from upstream.
    // -----------------------------------------------------------------------
    assign slot_ctrl_in[SLOT_MAIN] = main_from_skid ? slot_ctrl_out[SLOT_SKID] : InCtrl;
    assign slot_data_in[SLOT_MAIN] = main_from_skid ? slot_data_out[SLOT_SKID] : InData;
    assign slot_ctrl_in[SLOT_SKID] = InCtrl;
    assign slot_data_in[SLOT_SKID] = InData;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            pipe_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_entry (
                .clk          (Clk),
                .srst         (Reset),
                .load_i       (slot_load[gi]),
                .clear_ctrl_i (slot_clr[gi]),
                .ctrl_i       (slot_ctrl_in[gi]),
                .data_i       (slot_data_in[gi]),
                .ctrl_o       (slot_ctrl_out[gi]),
                .data_o       (slot_data_out[gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Stall counter. It saturates at all-ones and only Reset clears it.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !OutReady && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign InReady    = in_ready;
    assign OutValid   = out_valid_q;
    assign OutCtrl    = slot_ctrl_out[SLOT_MAIN];
    assign OutData    = slot_data_out[SLOT_MAIN];
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
// Drives two instances with identical stimulus: one at default widths and
// one with a 4-bit stall counter. The reference model is an ordered queue
// of accepted entries holding at most two. Entries enter when the stage
// holds fewer than two and neither Flush nor Reset is high. They leave from
// the head on a downstream transfer. Flush and Reset discard the queue.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = 96;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst       = 1'b1;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl   = '0;
    logic [DW-1:0] in_data   = '0;

    logic          a_in_ready, a_out_valid;
    logic [CW-1:0] a_out_ctrl;
    logic [DW-1:0] a_out_data;
    logic [15:0]   a_stall;

    logic          b_in_ready, b_out_valid;
    logic [CW-1:0] b_out_ctrl;
    logic [DW-1:0] b_out_data;
    logic [3:0]    b_stall;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
        .Clk(clk), .Reset(rst), .Flush(flush),
        .InValid(in_valid), .InReady(a_in_ready), .InCtrl(in_ctrl), .InData(in_data),
        .OutValid(a_out_valid), .OutReady(out_ready), .OutCtrl(a_out_ctrl),
        .OutData(a_out_data), .StallCount(a_stall)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut_c4 (
        .Clk(clk), .Reset(rst), .Flush(flush),
        .InValid(in_valid), .InReady(b_in_ready), .InCtrl(in_ctrl), .InData(in_data),
        .OutValid(b_out_valid), .OutReady(out_ready), .OutCtrl(b_out_ctrl),
        .OutData(b_out_data), .StallCount(b_stall)
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   live   = 1'b0;
    int   popped = 0;

    // -----------------------------------------------------------------------
    // Intake side: on each rising edge, record what the stage must have
    // accepted. The occupancy before the edge is the queue size plus any
    // entry the monitor removed for this edge's downstream transfer.
    // -----------------------------------------------------------------------
    initial begin
        int occ;
        forever begin
            @(posedge clk);
            occ = exp_q.size() + popped;
            if (rst) begin
                exp_q.delete();
                live = 1'b1;
            end else if (flush) begin
                exp_q.delete();
            end else if (in_valid && occ < 2) begin
                exp_q.push_back('{c: in_ctrl, d: in_data});
                $display("[%0t] in  ctrl=%02h data=%0h", $time, in_ctrl, in_data);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Monitor: checks the outputs mid-cycle and retires the head entry when
    // the downstream transfer will happen.
    // -----------------------------------------------------------------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    initial begin
        ent_t          h;
        bit            ev;
        logic [DW-1:0] last_shown;
        int            exp_stall;
        int            exp_stall4;
        last_shown = '0;
        exp_stall  = 0;
        exp_stall4 = 0;
        forever begin
            @(negedge clk);
            popped = 0;
            if (live) begin
                ev = (exp_q.size() > 0);
                h  = ev ? exp_q[0] : '0;

                chk("out_valid",    128'(a_out_valid), 128'(ev));
                chk("c4_out_valid", 128'(b_out_valid), 128'(ev));
                if (ev) begin
                    chk("out_ctrl",    128'(a_out_ctrl), 128'(h.c));
                    chk("out_data",    128'(a_out_data), 128'(h.d));
                    chk("c4_out_ctrl", 128'(b_out_ctrl), 128'(h.c));
                    chk("c4_out_data", 128'(b_out_data), 128'(h.d));
                    last_shown = h.d;
                end else begin
                    chk("idle_ctrl",    128'(a_out_ctrl), 128'(0));
                    chk("idle_data",    128'(a_out_data), 128'(last_shown));
                    chk("c4_idle_ctrl", 128'(b_out_ctrl), 128'(0));
                    chk("c4_idle_data", 128'(b_out_data), 128'(last_shown));
                end
                chk("in_ready",    128'(a_in_ready), 128'(exp_q.size() < 2 && !flush && !rst));
                chk("c4_in_ready", 128'(b_in_ready), 128'(exp_q.size() < 2 && !flush && !rst));
                chk("stall16", 128'(a_stall), 128'(exp_stall));
                chk("stall4",  128'(b_stall), 128'(exp_stall4));

                if (ev && out_ready) begin
                    void'(exp_q.pop_front());
                    popped = 1;
                    $display("[%0t] out ctrl=%02h data=%0h", $time, h.c, h.d);
                end
                if (rst) begin
                    exp_stall  = 0;
                    exp_stall4 = 0;
                    last_shown = '0;
                end else if (ev && !out_ready) begin
                    if (exp_stall < 65535) exp_stall++;
                    if (exp_stall4 < 15)   exp_stall4++;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic cyc(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input bit ordy, input bit fl, input bit rs);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
    endtask

    initial begin
        // Reset
        cyc(0, '0, '0, 0, 0, 1);
        cyc(0, '0, '0, 0, 0, 1);
        cyc(0, '0, '0, 1, 0, 0);

        // Streaming 1..4
        for (int i = 1; i <= 4; i++) cyc(1, 8'h81, DW'(i), 1, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);

        // Back-pressure 10, 11, 12
        cyc(1, 8'h42, DW'(10), 1, 0, 0);
        cyc(1, 8'h42, DW'(11), 0, 0, 0);
        cyc(1, 8'h42, DW'(12), 0, 0, 0);
        cyc(1, 8'h42, DW'(12), 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'h42, DW'(12), 1, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);

        // Flush in TWO with a simultaneous input
        cyc(1, 8'h13, DW'(20), 0, 0, 0);
        cyc(1, 8'h13, DW'(21), 0, 0, 0);
        cyc(1, 8'h13, DW'(22), 0, 1, 0);
        cyc(0, '0, '0, 1, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);

        // Reset mid-operation
        cyc(1, 8'hFF, DW'(5), 0, 0, 0);
        cyc(0, '0, '0, 0, 0, 1);
        cyc(0, '0, '0, 1, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);

        // Saturation of the 4-bit counter, with a flush in between
        cyc(1, 8'h07, DW'(40), 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, '0, '0, 0, 0, 0);
        cyc(0, '0, '0, 0, 1, 0);
        cyc(1, 8'h07, DW'(41), 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, '0, '0, 0, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);

        // Bubble between 30 and 31
        cyc(1, 8'h5A, DW'(30), 1, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);
        cyc(1, 8'h5A, DW'(31), 1, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 7,
                CW'($urandom()),
                {$urandom(), $urandom(), $urandom()},
                $urandom_range(0, 9) < 6,
                $urandom_range(0, 99) < 3,
                $urandom_range(0, 199) < 2);
        end

        cyc(0, '0, '0, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
